// File: rtl/thread_sched_pkg.sv
// Shared constants and helpers for the thread scheduler.
// Holds the thread-ID width function, the statistics counter width and
// the default thread count used by the top and the picker.
package thread_sched_pkg;

  localparam int STAT_W          = 32;
  localparam int DEF_NUM_THREADS = 4;

  // Thread-ID width: at least one bit even for a single-thread build.
  function automatic int tid_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Combinational circular search for the next eligible thread.
// With i_inclusive=1 the search starts at i_start; otherwise it starts at
// i_start+1 and visits i_start last. o_found=0 when no bit is set.
module rr_next_picker
  import thread_sched_pkg::*;
#(
  parameter int  NUM_THREADS = DEF_NUM_THREADS,
  localparam int TID_W       = tid_w(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] i_eligible,
  input  logic [TID_W-1:0]       i_start,
  input  logic                   i_inclusive,
  output logic [TID_W-1:0]       o_next,
  output logic                   o_found
);

  // Walk offsets from farthest to nearest so the nearest eligible thread wins.
  always_comb begin
    logic [TID_W-1:0] w_idx;
    o_next  = i_start;
    o_found = 1'b0;
    for (int k = NUM_THREADS - 1; k >= 0; k--) begin
      w_idx = TID_W'((int'(i_start) + (i_inclusive ? 0 : 1) + k) % NUM_THREADS);
      if (i_eligible[w_idx]) begin
        o_next  = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin hardware thread scheduler with a per-thread quantum.
// Optional feature: define THREAD_SCHED_STATS_EN to build one 32-bit
// saturating issue counter per thread, read through stat_sel/stat_count.
// Without it stat_count reads 0 and no counters exist.
module thread_scheduler
  import thread_sched_pkg::*;
#(
  parameter int  NUM_THREADS = DEF_NUM_THREADS,
  parameter int  QUANTUM     = 1,
  localparam int TID_W       = tid_w(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic [NUM_THREADS-1:0] thread_stall,
  output logic [TID_W-1:0]       thread,
  output logic                   thread_valid,
  output logic                   thread_switch,
  input  logic [TID_W-1:0]       stat_sel,
  output logic [STAT_W-1:0]      stat_count
);

  localparam int             QW    = $clog2(QUANTUM + 1);
  localparam logic [QW-1:0]  QLAST = QW'(QUANTUM - 1);

  logic [TID_W-1:0]       r_thread;
  logic                   r_valid;
  logic                   r_switch;
  logic [QW-1:0]          r_qcnt;

  logic [TID_W-1:0]       w_thread_next;
  logic                   w_valid_next;
  logic                   w_switch_next;
  logic [QW-1:0]          w_qcnt_next;

  logic [NUM_THREADS-1:0] w_eligible;
  logic                   w_hold;
  logic [TID_W-1:0]       w_pick;
  logic                   w_found;

  assign w_eligible = thread_active & ~thread_stall;

  // Keep the slot only while the running thread is still eligible and its
  // quantum has not run out; a stall therefore ends the quantum early.
  assign w_hold = r_valid && w_eligible[r_thread] && (r_qcnt < QLAST);

  // An idle scheduler resumes its search on the thread it stopped at.
  rr_next_picker #(
    .NUM_THREADS (NUM_THREADS)
  ) u_picker (
    .i_eligible  (w_eligible),
    .i_start     (r_thread),
    .i_inclusive (~r_valid),
    .o_next      (w_pick),
    .o_found     (w_found)
  );

  // Next-state selection: hold, rotate, or go idle; disabled edges freeze
  // thread and qcnt and drop valid.
  always_comb begin
    w_thread_next = r_thread;
    w_valid_next  = 1'b0;
    w_switch_next = 1'b0;
    w_qcnt_next   = r_qcnt;
    if (enable) begin
      if (w_hold) begin
        w_valid_next = 1'b1;
        w_qcnt_next  = r_qcnt + 1'b1;
      end else if (w_found) begin
        w_thread_next = w_pick;
        w_valid_next  = 1'b1;
        w_switch_next = (w_pick != r_thread);
        w_qcnt_next   = '0;
      end else begin
        w_qcnt_next = '0;
      end
    end
  end

  // Scheduler state register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thread <= '0;
      r_valid  <= 1'b0;
      r_switch <= 1'b0;
      r_qcnt   <= '0;
    end else begin
      r_thread <= w_thread_next;
      r_valid  <= w_valid_next;
      r_switch <= w_switch_next;
      r_qcnt   <= w_qcnt_next;
    end
  end

  assign thread        = r_thread;
  assign thread_valid  = r_valid;
  assign thread_switch = r_switch;

`ifdef THREAD_SCHED_STATS_EN
  logic [NUM_THREADS-1:0][STAT_W-1:0] w_cnt;

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_cnt
      logic [STAT_W-1:0] r_cnt;

      // Count every cycle this thread is presented as issuing; stick at max.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (r_valid && (r_thread == TID_W'(gi)) && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign stat_count = (32'(stat_sel) < NUM_THREADS) ? w_cnt[stat_sel] : '0;
`else
  logic w_unused_stat;
  assign w_unused_stat = ^stat_sel;
  assign stat_count    = '0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed testbench for thread_scheduler: one QUANTUM=1 and one QUANTUM=3
// instance share the same stimulus; each task checks the relevant instance.
// Statistics expectations follow THREAD_SCHED_STATS_EN.
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  thread_active = 4'b0000;
  logic [3:0]  thread_stall = 4'b0000;
  logic [1:0]  stat_sel = 2'd0;

  logic [1:0]  thr1, thr3;
  logic        val1, val3, sw1, sw3;
  logic [31:0] cnt1, cnt3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  thread_scheduler #(.NUM_THREADS(4), .QUANTUM(1)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .thread_active (thread_active),
    .thread_stall  (thread_stall),
    .thread        (thr1),
    .thread_valid  (val1),
    .thread_switch (sw1),
    .stat_sel      (stat_sel),
    .stat_count    (cnt1)
  );

  thread_scheduler #(.NUM_THREADS(4), .QUANTUM(3)) u_dut_q3 (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .thread_active (thread_active),
    .thread_stall  (thread_stall),
    .thread        (thr3),
    .thread_valid  (val3),
    .thread_switch (sw3),
    .stat_sel      (stat_sel),
    .stat_count    (cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d en=%0b act=%b stl=%b | q1 thr=%0d v=%0b sw=%0b | q3 thr=%0d v=%0b sw=%0b",
             cyc, enable, thread_active, thread_stall, thr1, val1, sw1, thr3, val3, sw3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    step();
    step();
    do_reset();
    n_cmp++;
    if (thr1 !== 2'd0 || val1 !== 1'b0 || sw1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_q1: got thr=%0d v=%0b sw=%0b, want thr=0 v=0 sw=0", thr1, val1, sw1);
    end
    n_cmp++;
    if (thr3 !== 2'd0 || val3 !== 1'b0 || sw3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_q3: got thr=%0d v=%0b sw=%0b, want thr=0 v=0 sw=0", thr3, val3, sw3);
    end
    stat_sel = 2'd0;
    #1;
    n_cmp++;
    if (cnt1 !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stat: got %0d, want 0", cnt1);
    end
  endtask

  task automatic test_round_robin();
    int exp_t [6] = '{0, 1, 2, 3, 0, 1};
    int exp_s [6] = '{0, 1, 1, 1, 1, 1};
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (thr1 !== exp_t[i][1:0] || val1 !== 1'b1 || sw1 !== exp_s[i][0]) begin
        n_bad++;
        $display("FAIL rr_%0d: got thr=%0d v=%0b sw=%0b, want thr=%0d v=1 sw=%0d",
                 i, thr1, val1, sw1, exp_t[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_stall();
    int exp_t [10] = '{0, 1, 3, 0, 1, 3, 0, 1, 2, 3};
    int exp_s [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0100;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 6) thread_stall = 4'b0000;
      step();
      n_cmp++;
      if (thr1 !== exp_t[i][1:0] || val1 !== 1'b1 || sw1 !== exp_s[i][0]) begin
        n_bad++;
        $display("FAIL stall_%0d: got thr=%0d v=%0b sw=%0b, want thr=%0d v=1 sw=%0d",
                 i, thr1, val1, sw1, exp_t[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_idle();
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    do_reset();
    step();
    step();
    thread_active = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (thr1 !== 2'd1 || val1 !== 1'b0 || sw1 !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_%0d: got thr=%0d v=%0b sw=%0b, want thr=1 v=0 sw=0", i, thr1, val1, sw1);
      end
    end
    thread_active = 4'b0100;
    step();
    n_cmp++;
    if (thr1 !== 2'd2 || val1 !== 1'b1 || sw1 !== 1'b1) begin
      n_bad++;
      $display("FAIL wake_t2: got thr=%0d v=%0b sw=%0b, want thr=2 v=1 sw=1", thr1, val1, sw1);
    end
    thread_active = 4'b0000;
    step();
    thread_active = 4'b1111;
    step();
    n_cmp++;
    if (thr1 !== 2'd2 || val1 !== 1'b1 || sw1 !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_inclusive: got thr=%0d v=%0b sw=%0b, want thr=2 v=1 sw=0", thr1, val1, sw1);
    end
  endtask

  task automatic test_quantum();
    int exp_t [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 3, 0};
    int exp_s [12] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) thread_stall = 4'b0100;
      step();
      n_cmp++;
      if (thr3 !== exp_t[i][1:0] || val3 !== 1'b1 || sw3 !== exp_s[i][0]) begin
        n_bad++;
        $display("FAIL quantum_%0d: got thr=%0d v=%0b sw=%0b, want thr=%0d v=1 sw=%0d",
                 i, thr3, val3, sw3, exp_t[i], exp_s[i]);
      end
    end
    thread_stall = 4'b0000;
  endtask

  task automatic test_enable();
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    do_reset();
    step();
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (thr1 !== 2'd2 || val1 !== 1'b0 || sw1 !== 1'b0) begin
        n_bad++;
        $display("FAIL disabled_%0d: got thr=%0d v=%0b sw=%0b, want thr=2 v=0 sw=0", i, thr1, val1, sw1);
      end
    end
    enable = 1'b1;
    step();
    n_cmp++;
    if (thr1 !== 2'd2 || val1 !== 1'b1 || sw1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reenable: got thr=%0d v=%0b sw=%0b, want thr=2 v=1 sw=0", thr1, val1, sw1);
    end
    step();
    n_cmp++;
    if (thr1 !== 2'd3 || val1 !== 1'b1 || sw1 !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reenable: got thr=%0d v=%0b sw=%0b, want thr=3 v=1 sw=1", thr1, val1, sw1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (thr1 !== 2'd0 || val1 !== 1'b0 || sw1 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: got thr=%0d v=%0b sw=%0b, want thr=0 v=0 sw=0", thr1, val1, sw1);
    end
    n_cmp++;
    if (thr3 !== 2'd0 || val3 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset_q3: got thr=%0d v=%0b, want thr=0 v=0", thr3, val3);
    end
  endtask

  task automatic test_stats();
`ifdef THREAD_SCHED_STATS_EN
    int exp1 [4] = '{2, 2, 2, 2};
    int exp3 [4] = '{3, 3, 2, 0};
`else
    int exp1 [4] = '{0, 0, 0, 0};
    int exp3 [4] = '{0, 0, 0, 0};
`endif
    enable        = 1'b1;
    thread_active = 4'b1111;
    thread_stall  = 4'b0000;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    enable = 1'b0;
    step();
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      n_cmp++;
      if (cnt1 !== 32'(exp1[s]) || cnt3 !== 32'(exp3[s])) begin
        n_bad++;
        $display("FAIL stats_sel%0d: got q1=%0d q3=%0d, want q1=%0d q3=%0d",
                 s, cnt1, cnt3, exp1[s], exp3[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_idle();
    test_quantum();
    test_enable();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, number of hardware threads (2..16).
REQ-002 SHALL have parameter QUANTUM, default 1, cycles a thread holds its slot (1 = fine-grain round-robin).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  scheduler advance enable.
REQ-006 SHALL have port thread_active  input  NUM_THREADS  per-thread runnable mask.
REQ-007 SHALL have port thread_stall  input  NUM_THREADS  per-thread stall.
REQ-008 SHALL have port thread  output  TID_W  registered selected thread ID, TID_W = max(1, clog2(NUM_THREADS)).
REQ-009 SHALL have port thread_valid  output  1  registered, selected thread is issuing this cycle.
REQ-010 SHALL have port thread_switch  output  1  registered one-cycle pulse, selection changed on last edge.
REQ-011 SHALL have port stat_sel  input  TID_W  statistics read select.
REQ-012 SHALL have port stat_count  output  32  combinational read of the selected thread's issue counter.

Function
REQ-013 SHALL define eligible = thread_active & ~thread_stall, sampled every cycle.
REQ-014 SHALL keep a quantum counter qcnt of width clog2(QUANTUM+1).
REQ-015 SHALL, on an edge with enable=1, hold thread and increment qcnt when thread_valid=1, the current thread is eligible and qcnt < QUANTUM-1.
REQ-016 SHALL otherwise select the first eligible thread in circular order, starting at current+1 and wrapping past NUM_THREADS-1 to 0, with current last; qcnt resets to 0.
REQ-017 SHALL, when thread_valid=0 before the edge, start the search at the current thread inclusive, so an idle scheduler resumes on the thread it stopped at.
REQ-018 SHALL, when no thread is eligible, hold thread, set thread_valid=0 and reset qcnt to 0.
REQ-019 SHALL set thread_valid=1 whenever any thread is eligible on an enabled edge.
REQ-020 SHALL pulse thread_switch=1 for one cycle when the new thread differs from the old thread and the new thread_valid=1; otherwise thread_switch=0.
REQ-021 SHALL, on an edge with enable=0, hold thread and qcnt and set thread_valid=0 and thread_switch=0.
REQ-022 SHALL select a newly eligible thread on the first enabled edge after it becomes eligible, giving one-cycle latency from eligibility to selection.
REQ-023 SHALL treat a stall of the current thread mid-quantum as quantum expiry, switching on the next enabled edge.

Reset
REQ-024 SHALL, on rst=1 at an edge, set thread=0, thread_valid=0, thread_switch=0, qcnt=0 and all issue counters to 0.
REQ-025 SHALL give rst priority over enable and over all other inputs, including mid-quantum and mid-search.

Configuration
REQ-026 SHALL, with macro THREAD_SCHED_STATS_EN defined, keep one 32-bit saturating issue counter per thread that increments on each edge where that thread is registered as thread with thread_valid=1.
REQ-027 SHALL, without THREAD_SCHED_STATS_EN, keep the stat_sel and stat_count ports, tie stat_count to 0 and implement no counters.

Structure
REQ-028 SHALL place the TID_W computation function, the STAT_W=32 constant and the NUM_THREADS default in shared package thread_sched_pkg.
REQ-029 SHALL implement the circular search in one combinational sub-module, rr_next_picker (inputs: eligible mask, start index, inclusive flag; outputs: next index, found).

Verification (NUM_THREADS=4 unless stated)
REQ-030 SHALL cover: QUANTUM=1, rst then enable=1, active=4'b1111, stall=0 -> thread 0,1,2,3,0,... with valid=1 and switch=1 each cycle after the first grant.
REQ-031 SHALL cover: stall=4'b0100 -> thread 0,1,3,0,1,3; stall released -> thread 2 is included on the next rotation.
REQ-032 SHALL cover: active=0 -> valid=0, thread held; then active=4'b0100 -> thread=2, valid=1, switch=1 one edge later.
REQ-033 SHALL cover: QUANTUM=3, all eligible -> each thread held 3 cycles; stall the current thread on its 2nd cycle -> switch on the next edge and the next thread gets a full 3 cycles.
REQ-034 SHALL cover: enable=0 while thread=2 -> thread=2, valid=0; enable=1 -> resume on thread 2; rst=1 mid-run -> thread=0, valid=0 at the next edge.
REQ-035 SHALL cover: with THREAD_SCHED_STATS_EN, 8 enabled cycles all eligible -> stat_count=2 for every stat_sel; without the macro -> stat_count=0.
